// File: rtl/parallel_in_serial_out_enable_fsm.sv
// Parallel-load, serial-out shift register with shift enable and a load/busy/done handshake.
// One WIDTH-bit word is serialised over WIDTH enabled edges; Done pulses for one cycle afterwards.
module parallel_in_serial_out_enable_fsm #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           Load,
  input  logic [WIDTH-1:0]               ParallelIn,
  input  logic                           ShiftEn,
  input  logic                           ShiftIn,
  output logic                           ShiftOut,
  output logic                           Busy,
  output logic                           Done,
  output logic [$clog2(WIDTH+1)-1:0]     BitCount
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [WIDTH-1:0]   shifted;

  // Fill bit enters at the end opposite the output end.
  always_comb begin
    if (MSB_FIRST) begin
      shifted = {shreg_q[WIDTH-2:0], ShiftIn};
    end else begin
      shifted = {ShiftIn, shreg_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; Load is only honoured in IDLE and DONE so a word in flight is never corrupted.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (Load) begin
          shreg_d = ParallelIn;
          cnt_d   = CNT_W'(WIDTH);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ShiftEn) begin
          shreg_d = shifted;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (Load) begin
          shreg_d = ParallelIn;
          cnt_d   = CNT_W'(WIDTH);
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign ShiftOut = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign Busy     = (state_q == ST_SHIFT);
  assign Done     = (state_q == ST_DONE);
  assign BitCount = cnt_q;

endmodule

// File: tb/tb_parallel_in_serial_out_enable_fsm.sv
// Directed testbench: an MSB-first and an LSB-first instance share all inputs;
// a behavioural receiver register models the loopback partner.
module tb_parallel_in_serial_out_enable_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [3:0] pin = 4'h0;
  logic       sen = 1'b0;
  logic       sin = 1'b0;

  logic       out_m, busy_m, done_m;
  logic [2:0] cnt_m;
  logic       out_l, busy_l, done_l;
  logic [2:0] cnt_l;

  logic [3:0] rx_q;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  parallel_in_serial_out_enable_fsm #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .Clk(clk), .Reset(rst), .Load(load), .ParallelIn(pin), .ShiftEn(sen), .ShiftIn(sin),
    .ShiftOut(out_m), .Busy(busy_m), .Done(done_m), .BitCount(cnt_m)
  );

  parallel_in_serial_out_enable_fsm #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .Clk(clk), .Reset(rst), .Load(load), .ParallelIn(pin), .ShiftEn(sen), .ShiftIn(sin),
    .ShiftOut(out_l), .Busy(busy_l), .Done(done_l), .BitCount(cnt_l)
  );

  // Receiver: serial-in parallel-out with the same ShiftEn, fed by the MSB-first output.
  always_ff @(posedge clk) begin
    if (sen) rx_q <= {rx_q[2:0], out_m};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    load = 1'b0; sen = 1'b0; sin = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({busy_m, done_m, cnt_m, out_m} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_msb: got busy=%b done=%b cnt=%0d out=%b, expected all 0", busy_m, done_m, cnt_m, out_m);
    end
    n_checks++;
    if ({busy_l, done_l, cnt_l, out_l} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_lsb: got busy=%b done=%b cnt=%0d out=%b, expected all 0", busy_l, done_l, cnt_l, out_l);
    end
    // ShiftEn alone must not move IDLE.
    sen = 1'b1; sin = 1'b1;
    tick(); tick();
    n_checks++;
    if ({busy_m, cnt_m, out_m} !== 5'b0) begin
      n_fail++;
      $display("FAIL idle_ignores_shiften: got busy=%b cnt=%0d out=%b, expected 0 0 0", busy_m, cnt_m, out_m);
    end
    sen = 1'b0; sin = 1'b0;
  endtask

  task automatic test_reset_mid_word();
    logic [3:0] exp_state;
    do_reset();
    load = 1'b1; pin = 4'b1011;
    tick();
    load = 1'b0; sen = 1'b1;
    tick(); tick();
    n_checks++;
    if (cnt_m !== 3'd2 || busy_m !== 1'b1) begin
      n_fail++;
      $display("FAIL midword_pre: got cnt=%0d busy=%b, expected 2 1", cnt_m, busy_m);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; sen = 1'b0;
    exp_state = 4'b0;
    n_checks++;
    if ({busy_m, done_m, cnt_m[1:0], out_m} !== {exp_state, 1'b0}) begin
      n_fail++;
      $display("FAIL midword_reset: got busy=%b done=%b cnt=%0d out=%b, expected all 0", busy_m, done_m, cnt_m, out_m);
    end
    tick();
    n_checks++;
    if (busy_m !== 1'b0 || cnt_m !== 3'd0) begin
      n_fail++;
      $display("FAIL midword_stays_idle: got busy=%b cnt=%0d, expected 0 0", busy_m, cnt_m);
    end
  endtask

  task automatic test_msb_first();
    logic [3:0] word;
    int busy_cycles;
    word = 4'b1011;
    busy_cycles = 0;
    do_reset();
    load = 1'b1; pin = word; sen = 1'b1; sin = 1'b0;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (busy_m) busy_cycles++;
      n_checks++;
      if (out_m !== word[3-i] || cnt_m !== 3'(4 - i) || done_m !== 1'b0) begin
        n_fail++;
        $display("FAIL msb_bit%0d: got out=%b cnt=%0d done=%b, expected out=%b cnt=%0d done=0",
                 i, out_m, cnt_m, done_m, word[3-i], 4 - i);
      end
      tick();
    end
    n_checks++;
    if (done_m !== 1'b1 || busy_m !== 1'b0 || cnt_m !== 3'd0) begin
      n_fail++;
      $display("FAIL msb_done: got done=%b busy=%b cnt=%0d, expected 1 0 0", done_m, busy_m, cnt_m);
    end
    sen = 1'b0;
    tick();
    n_checks++;
    if (done_m !== 1'b0 || busy_m !== 1'b0 || busy_cycles != 4) begin
      n_fail++;
      $display("FAIL msb_after_done: got done=%b busy=%b busy_cycles=%0d, expected 0 0 4", done_m, busy_m, busy_cycles);
    end
  endtask

  task automatic test_lsb_gaps();
    logic [3:0] word;
    word = 4'b0110;
    do_reset();
    load = 1'b1; pin = word; sen = 1'b0; sin = 1'b0;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_l !== word[i] || cnt_l !== 3'(4 - i)) begin
        n_fail++;
        $display("FAIL lsb_bit%0d: got out=%b cnt=%0d, expected out=%b cnt=%0d", i, out_l, cnt_l, word[i], 4 - i);
      end
      sen = 1'b0;
      tick(); tick();
      n_checks++;
      if (out_l !== word[i] || cnt_l !== 3'(4 - i) || busy_l !== 1'b1) begin
        n_fail++;
        $display("FAIL lsb_hold%0d: got out=%b cnt=%0d busy=%b, expected out=%b cnt=%0d busy=1",
                 i, out_l, cnt_l, busy_l, word[i], 4 - i);
      end
      sen = 1'b1;
      tick();
    end
    sen = 1'b0;
    n_checks++;
    if (done_l !== 1'b1 || cnt_l !== 3'd0) begin
      n_fail++;
      $display("FAIL lsb_done: got done=%b cnt=%0d, expected 1 0", done_l, cnt_l);
    end
  endtask

  task automatic test_load_during_shift();
    logic [3:0] exp_out;
    logic [2:0] exp_cnt [4];
    exp_out = 4'b1100;
    exp_cnt = '{3'd4, 3'd3, 3'd2, 3'd1};
    do_reset();
    load = 1'b1; pin = 4'b1100; sen = 1'b0;
    tick();
    load = 1'b0; sen = 1'b1;
    tick();
    load = 1'b1; pin = 4'b0011;
    for (int i = 1; i < 4; i++) begin
      n_checks++;
      if (out_m !== exp_out[3-i] || cnt_m !== exp_cnt[i]) begin
        n_fail++;
        $display("FAIL ldshift_bit%0d: got out=%b cnt=%0d, expected out=%b cnt=%0d",
                 i, out_m, cnt_m, exp_out[3-i], exp_cnt[i]);
      end
      tick();
    end
    n_checks++;
    if (done_m !== 1'b1 || cnt_m !== 3'd0) begin
      n_fail++;
      $display("FAIL ldshift_done: got done=%b cnt=%0d, expected 1 0", done_m, cnt_m);
    end
    load = 1'b0; sen = 1'b0;
    tick();
    n_checks++;
    if (busy_m !== 1'b0 || done_m !== 1'b0) begin
      n_fail++;
      $display("FAIL ldshift_idle: got busy=%b done=%b, expected 0 0", busy_m, done_m);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] word_b;
    word_b = 4'b1001;
    do_reset();
    load = 1'b1; pin = 4'b1011; sen = 1'b1; sin = 1'b0;
    tick();
    load = 1'b0;
    tick(); tick(); tick();
    load = 1'b1; pin = word_b;
    tick();
    n_checks++;
    if (done_m !== 1'b1 || busy_m !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done: got done=%b busy=%b, expected 1 0", done_m, busy_m);
    end
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_m !== word_b[3-i] || cnt_m !== 3'(4 - i) || busy_m !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_bit%0d: got out=%b cnt=%0d busy=%b, expected out=%b cnt=%0d busy=1",
                 i, out_m, cnt_m, busy_m, word_b[3-i], 4 - i);
      end
      tick();
    end
    sen = 1'b0;
    n_checks++;
    if (done_m !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second_done: got done=%b, expected 1", done_m);
    end
  endtask

  task automatic test_loopback();
    do_reset();
    load = 1'b1; pin = 4'b1010; sen = 1'b0; sin = 1'b1;
    tick();
    load = 1'b0; sen = 1'b1;
    tick(); tick(); tick(); tick();
    sen = 1'b0;
    n_checks++;
    if (done_m !== 1'b1 || rx_q !== 4'b1010) begin
      n_fail++;
      $display("FAIL loopback: got done=%b rx=%b, expected done=1 rx=1010", done_m, rx_q);
    end
    tick();
    n_checks++;
    if (out_m !== 1'b1 || busy_m !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_history: got out=%b busy=%b, expected out=1 busy=0", out_m, busy_m);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_mid_word();
    test_msb_first();
    test_lsb_gaps();
    test_load_during_shift();
    test_back_to_back();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
